// File: rtl/acc_pkg.sv
// Shared types and arithmetic for the per-column partial-sum accumulator.
// The add helper works at a fixed wide width so any ACC_WIDTH up to 63 bits can reuse it.
package acc_pkg;

    typedef enum logic [1:0] {
        COL_FILL  = 2'd0,
        COL_ACCUM = 2'd1,
        COL_DRAIN = 2'd2
    } col_state_e;

    localparam int SAT_CALC_W = 64;

    // Operands arrive sign-extended to SAT_CALC_W; the caller truncates to its own width,
    // which yields modulo wrap when sat_en is low.
    function automatic logic [SAT_CALC_W-1:0] acc_add(
        input logic [SAT_CALC_W-1:0] a,
        input logic [SAT_CALC_W-1:0] b,
        input int                    width,
        input logic                  sat_en
    );
        logic signed [SAT_CALC_W:0] sum;
        logic signed [SAT_CALC_W:0] lim_max;
        logic signed [SAT_CALC_W:0] lim_min;
        sum     = $signed({a[SAT_CALC_W-1], a}) + $signed({b[SAT_CALC_W-1], b});
        lim_max = $signed(({{SAT_CALC_W{1'b0}}, 1'b1} << (width - 1)) - {{SAT_CALC_W{1'b0}}, 1'b1});
        lim_min = ~lim_max;
        if (sat_en && (sum > lim_max)) begin
            return lim_max[SAT_CALC_W-1:0];
        end else if (sat_en && (sum < lim_min)) begin
            return lim_min[SAT_CALC_W-1:0];
        end
        return sum[SAT_CALC_W-1:0];
    endfunction

endpackage

// File: rtl/acc_column.sv
// One accumulator column: fills a tile, accumulates further passes onto it, then drains it.
module acc_column
    import acc_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PASS_W     = 4,
    parameter int SAT_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic [PASS_W-1:0]    cfg_pass_i,
    input  logic                 psum_en_i,
    input  logic [IN_WIDTH-1:0]  psum_i,
    input  logic                 rden_i,
    output logic [ACC_WIDTH-1:0] rd_data_o,
    output logic                 valid_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FIFO_DEPTH - 1);

    col_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic [PASS_W-1:0]    npass_q, npass_d;
    logic                 err_q, err_d;
    logic                 valid_q, valid_d;
    logic [ACC_WIDTH-1:0] data_q, data_d;
    logic [ACC_WIDTH-1:0] buf_q [FIFO_DEPTH];

    logic                 wr_en;
    logic [ACC_WIDTH-1:0] wr_data;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [PASS_W-1:0]    pass_inc;
    logic [PASS_W-1:0]    cfg_eff;

    assign in_ext   = ACC_WIDTH'($signed(psum_i));
    assign acc_sum  = ACC_WIDTH'(acc_add(SAT_CALC_W'($signed(buf_q[idx_q])),
                                         SAT_CALC_W'($signed(in_ext)),
                                         ACC_WIDTH, SAT_EN != 0));
    assign pass_inc = pass_q + PASS_W'(1);
    assign cfg_eff  = (cfg_pass_i == '0) ? PASS_W'(1) : cfg_pass_i;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rd_idx_d = rd_idx_q;
        pass_d   = pass_q;
        npass_d  = npass_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        wr_en    = 1'b0;
        wr_data  = in_ext;
        if (clear_i) begin
            state_d  = COL_FILL;
            idx_d    = '0;
            rd_idx_d = '0;
            pass_d   = '0;
            npass_d  = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                COL_FILL, COL_ACCUM: begin
                    if (rden_i) err_d = 1'b1;
                    if (psum_en_i) begin
                        wr_en   = 1'b1;
                        wr_data = (state_q == COL_ACCUM) ? acc_sum : in_ext;
                        idx_d   = idx_q + IDX_W'(1);
                        // The pass count is captured once per tile, on its very first row.
                        if ((state_q == COL_FILL) && (idx_q == '0)) npass_d = cfg_eff;
                        if (idx_q == IDX_LAST) begin
                            pass_d  = pass_inc;
                            state_d = (pass_inc == npass_d) ? COL_DRAIN : COL_ACCUM;
                        end
                    end
                end
                COL_DRAIN: begin
                    if (psum_en_i) err_d = 1'b1;
                    if (rden_i) begin
                        valid_d  = 1'b1;
                        data_d   = buf_q[rd_idx_q];
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                        if (rd_idx_q == IDX_LAST) begin
                            state_d  = COL_FILL;
                            idx_d    = '0;
                            rd_idx_d = '0;
                            pass_d   = '0;
                        end
                    end
                end
                default: state_d = COL_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COL_FILL;
            idx_q    <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
            npass_q  <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
            npass_q  <= npass_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Tile storage is never reset; every tile overwrites all rows in its fill pass.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[idx_q] <= wr_data;
    end

    assign rd_data_o = data_q;
    assign valid_o   = valid_q;
    assign done_o    = (state_q == COL_DRAIN);
    assign err_o     = err_q;

endmodule

// File: rtl/psum_accumulator.sv
// Bank of PE_SIZE independent partial-sum accumulator columns sharing clock, reset and clear.
module psum_accumulator #(
    parameter int PE_SIZE    = 4,
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_PASS   = 8,
    parameter int SAT_EN     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    input  logic [$clog2(MAX_PASS+1)-1:0]  cfg_pass_i,
    input  logic [PE_SIZE-1:0]             psum_en_i,
    input  logic [IN_WIDTH*PE_SIZE-1:0]    psum_row_i,
    input  logic [PE_SIZE-1:0]             rden_i,
    output logic [ACC_WIDTH*PE_SIZE-1:0]   psum_row_o,
    output logic [PE_SIZE-1:0]             valid_o,
    output logic [PE_SIZE-1:0]             done_o,
    output logic [PE_SIZE-1:0]             err_o
);

    localparam int PASS_W = $clog2(MAX_PASS + 1);

    for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
        acc_column #(
            .IN_WIDTH   (IN_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .PASS_W     (PASS_W),
            .SAT_EN     (SAT_EN)
        ) u_col (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (clear_i),
            .cfg_pass_i (cfg_pass_i),
            .psum_en_i  (psum_en_i[c]),
            .psum_i     (psum_row_i[c*IN_WIDTH +: IN_WIDTH]),
            .rden_i     (rden_i[c]),
            .rd_data_o  (psum_row_o[c*ACC_WIDTH +: ACC_WIDTH]),
            .valid_o    (valid_o[c]),
            .done_o     (done_o[c]),
            .err_o      (err_o[c])
        );
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench: a saturating and a wrapping instance driven by the same stimulus.
module tb_psum_accumulator;

    localparam int PE    = 4;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXP  = 8;
    localparam int PW    = $clog2(MAXP + 1);

    logic              clk = 1'b0;
    logic              rstN;
    logic              clearI;
    logic [PW-1:0]     cfgPass;
    logic [PE-1:0]     psumEn;
    logic [IW*PE-1:0]  psumRow;
    logic [PE-1:0]     rden;
    logic [AW*PE-1:0]  rowSat, rowWrap;
    logic [PE-1:0]     validSat, validWrap, doneSat, doneWrap, errSat, errWrap;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.PE_SIZE(PE), .IN_WIDTH(IW), .ACC_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                       .MAX_PASS(MAXP), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rstN), .clear_i(clearI), .cfg_pass_i(cfgPass),
        .psum_en_i(psumEn), .psum_row_i(psumRow), .rden_i(rden),
        .psum_row_o(rowSat), .valid_o(validSat), .done_o(doneSat), .err_o(errSat)
    );

    psum_accumulator #(.PE_SIZE(PE), .IN_WIDTH(IW), .ACC_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                       .MAX_PASS(MAXP), .SAT_EN(0)) dutWrap (
        .clk(clk), .rst_n(rstN), .clear_i(clearI), .cfg_pass_i(cfgPass),
        .psum_en_i(psumEn), .psum_row_i(psumRow), .rden_i(rden),
        .psum_row_o(rowWrap), .valid_o(validWrap), .done_o(doneWrap), .err_o(errWrap)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [PE-1:0] en, input logic [IW*PE-1:0] row, input logic [PE-1:0] rd);
        psumEn  = en;
        psumRow = row;
        rden    = rd;
        tick();
        psumEn  = '0;
        rden    = '0;
    endtask

    task automatic pulseClear(input logic [PE-1:0] en, input logic [PE-1:0] rd);
        clearI = 1'b1;
        applyStimulus(en, {PE{32'h5A5A_5A5A}}, rd);
        clearI = 1'b0;
    endtask

    function automatic logic [31:0] colOf(input logic [AW*PE-1:0] r, input int c);
        return r[c*AW +: AW];
    endfunction

    // Two-pass tile: row i gets (i+1) then 0x100*(i+1) in every column, so each row sums to 0x101*(i+1).
    task automatic runTwoPassTile(input string tag);
        cfgPass = PW'(2);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] v;
                v = (p == 0) ? 32'(i + 1) : 32'(32'h100 * (i + 1));
                applyStimulus('1, {PE{v}}, '0);
            end
        end
        checkOutput({tag, "_done"}, 32'(doneSat), 32'hF);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus('0, '0, '1);
            checkOutput({tag, "_col0"}, colOf(rowSat, 0), 32'(32'h101 * (i + 1)));
            checkOutput({tag, "_col3"}, colOf(rowSat, 3), 32'(32'h101 * (i + 1)));
        end
        checkOutput({tag, "_doneAfter"}, 32'(doneSat), 32'h0);
    endtask

    // Fill six rows of a three-pass tile so every column sits in ACCUM at pass 2, row 2.
    task automatic partialTile();
        cfgPass = PW'(3);
        for (int n = 0; n < 6; n++) applyStimulus('1, {PE{32'h1111}}, '0);
    endtask

    initial begin
        logic [31:0] accVal [DEPTH];
        rstN    = 1'b0;
        clearI  = 1'b0;
        cfgPass = '0;
        psumEn  = '0;
        psumRow = '0;
        rden    = '0;
        #3;
        checkOutput("rst_valid", 32'(validSat), 32'h0);
        checkOutput("rst_done",  32'(doneSat),  32'h0);
        checkOutput("rst_err",   32'(errSat),   32'h0);
        checkOutput("rst_row0",  colOf(rowSat, 0), 32'h0);
        #20;
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Four-pass tile: fill rows 4..7 (+column index), then three accumulate passes.
        for (int i = 0; i < DEPTH; i++) accVal[i] = 32'h10 << (4 * i);
        cfgPass = PW'(4);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [IW*PE-1:0] r;
                for (int c = 0; c < PE; c++) r[c*IW +: IW] = (p == 0) ? 32'(4 + i + c) : accVal[i];
                applyStimulus('1, r, '0);
                if (p * 4 + i == 14) checkOutput("p4_doneEarly", 32'(doneSat), 32'h0);
            end
        end
        checkOutput("p4_done", 32'(doneSat), 32'hF);
        checkOutput("p4_validIdle", 32'(validSat), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus('0, '0, '1);
            checkOutput("p4_valid", 32'(validSat), 32'hF);
            for (int c = 0; c < PE; c++)
                checkOutput("p4_data", colOf(rowSat, c), 32'(4 + i + c) + 32'd3 * accVal[i]);
            tick();
            checkOutput("p4_validDrop", 32'(validSat), 32'h0);
            checkOutput("p4_hold", colOf(rowSat, 0), 32'(4 + i) + 32'd3 * accVal[i]);
        end
        checkOutput("p4_doneClear", 32'(doneSat), 32'h0);
        checkOutput("p4_err", 32'(errSat), 32'h0);

        // Single-pass tile with extra writes while draining.
        cfgPass = PW'(1);
        for (int i = 0; i < DEPTH; i++) applyStimulus('1, {PE{32'hA0 + 32'(i)}}, '0);
        checkOutput("p1_done", 32'(doneSat), 32'hF);
        checkOutput("p1_errBefore", 32'(errSat), 32'h0);
        applyStimulus('1, {PE{32'hDEAD}}, '0);
        applyStimulus('1, {PE{32'hBEEF}}, '0);
        checkOutput("p1_errAfter", 32'(errSat), 32'hF);
        checkOutput("p1_doneHeld", 32'(doneSat), 32'hF);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus('0, '0, '1);
            checkOutput("p1_data", colOf(rowSat, 2), 32'hA0 + 32'(i));
        end
        pulseClear('0, '0);
        checkOutput("p1_errCleared", 32'(errSat), 32'h0);

        // Saturation versus wrap at the signed 32-bit limits.
        cfgPass = PW'(2);
        applyStimulus('1, {PE{32'h7FFF_FFF0}}, '0);
        applyStimulus('1, {PE{32'h8000_0010}}, '0);
        applyStimulus('1, {PE{32'h1}}, '0);
        applyStimulus('1, {PE{32'h2}}, '0);
        applyStimulus('1, {PE{32'h20}}, '0);
        applyStimulus('1, {PE{32'hFFFF_FFE0}}, '0);
        applyStimulus('1, {PE{32'h3}}, '0);
        applyStimulus('1, {PE{32'h4}}, '0);
        checkOutput("sat_done", 32'(doneWrap), 32'hF);
        applyStimulus('0, '0, '1);
        checkOutput("sat_max",  colOf(rowSat, 0),  32'h7FFF_FFFF);
        checkOutput("wrap_max", colOf(rowWrap, 0), 32'h8000_0010);
        applyStimulus('0, '0, '1);
        checkOutput("sat_min",  colOf(rowSat, 1),  32'h8000_0000);
        checkOutput("wrap_min", colOf(rowWrap, 1), 32'h7FFF_FFF0);
        applyStimulus('0, '0, '1);
        checkOutput("sat_plain2", colOf(rowSat, 2), 32'h4);
        applyStimulus('0, '0, '1);
        checkOutput("sat_plain3", colOf(rowWrap, 3), 32'h6);

        // Independent columns: col1 every cycle, col0 every other cycle.
        cfgPass = PW'(2);
        for (int k = 0; k < 16; k++) begin
            logic [IW*PE-1:0] r;
            logic [PE-1:0] en;
            r  = '0;
            en = '0;
            if (k % 2 == 0) begin
                en[0] = 1'b1;
                r[0*IW +: IW] = 32'(k / 2 + 1);
            end
            if (k < 8) begin
                en[1] = 1'b1;
                r[1*IW +: IW] = 32'(32'h10 * (k + 1));
            end
            applyStimulus(en, r, '0);
            if (k == 6)  checkOutput("ind_col1Early", 32'(doneSat[1]), 32'h0);
            if (k == 7)  checkOutput("ind_col1Done",  32'(doneSat[1]), 32'h1);
            if (k == 7)  checkOutput("ind_col0Busy",  32'(doneSat[0]), 32'h0);
            if (k == 12) checkOutput("ind_col0Early", 32'(doneSat[0]), 32'h0);
            if (k == 14) checkOutput("ind_col0Done",  32'(doneSat[0]), 32'h1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus('0, '0, 4'b0011);
            checkOutput("ind_valid", 32'(validSat), 32'h3);
            checkOutput("ind_col0", colOf(rowSat, 0), 32'(2 * i + 6));
            checkOutput("ind_col1", colOf(rowSat, 1), 32'(32'h10 * (2 * i + 6)));
        end
        checkOutput("ind_err", 32'(errSat), 32'h0);

        // Read strobe while filling, then abort a partial tile with clear.
        applyStimulus('0, '0, '1);
        checkOutput("fillRd_err",   32'(errSat),   32'hF);
        checkOutput("fillRd_valid", 32'(validSat), 32'h0);
        partialTile();
        pulseClear('1, '1);
        checkOutput("clr_valid", 32'(validSat), 32'h0);
        checkOutput("clr_done",  32'(doneSat),  32'h0);
        checkOutput("clr_err",   32'(errSat),   32'h0);
        runTwoPassTile("clrTile");

        // Same abort by asynchronous reset, sampled with no clock edge.
        partialTile();
        applyStimulus('0, '0, '1);
        checkOutput("rstMid_errSet", 32'(errSat), 32'hF);
        rstN = 1'b0;
        #2;
        checkOutput("rstMid_err",  32'(errSat),  32'h0);
        checkOutput("rstMid_done", 32'(doneSat), 32'h0);
        checkOutput("rstMid_row0", colOf(rowSat, 0), 32'h0);
        checkOutput("rstMid_row3", colOf(rowSat, 3), 32'h0);
        rstN = 1'b1;
        tick();
        runTwoPassTile("rstTile");

        // Pass count change mid-tile must not affect the tile in progress.
        cfgPass = PW'(2);
        applyStimulus('1, {PE{32'h1}}, '0);
        cfgPass = PW'(5);
        for (int n = 1; n < 8; n++) begin
            applyStimulus('1, {PE{32'h1}}, '0);
            if (n == 6) checkOutput("cfgChg_early", 32'(doneSat), 32'h0);
        end
        checkOutput("cfgChg_done", 32'(doneSat), 32'hF);
        applyStimulus('0, '0, '1);
        checkOutput("cfgChg_data", colOf(rowSat, 1), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
